// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that turns per-button press pulses into a FWFT event FIFO.
// Optional auto-repeat on held buttons is built when BUTTON_AUTOREPEAT_EN is defined.
module button_event_arbiter #(
  parameter int N_BTN         = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  localparam int IDW          = $clog2(N_BTN)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_BTN-1:0]              btn_pulse,
  input  logic [N_BTN-1:0]              btn_level,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [IDW-1:0]                evt_id,
  output logic                          evt_repeat,
  output logic [N_BTN-1:0]              pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int EW = IDW + 1;
`else
  localparam int EW = IDW;
`endif

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   next_rr;
  logic             grant;
  logic             pop;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] req;
  logic [EW-1:0]    entry;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // First pending bit at or above rr_ptr, wrapping.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    found  = 1'b0;
    idx    = '0;
    win_id = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % N_BTN);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  assign grant   = (|pending) && (fifo_count != FULL_CNT);
  assign pop     = (fifo_count != '0) && evt_ready;
  assign next_rr = (win_id == IDW'(N_BTN - 1)) ? '0 : win_id + 1'b1;

  for (genvar g = 0; g < N_BTN; g++) begin : g_grant
    assign grant_vec[g] = grant && (win_id == IDW'(g));
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX) + 1;
  localparam logic [RCW-1:0] DLY = RCW'(REPEAT_DELAY);
  localparam logic [RCW-1:0] PER = RCW'(REPEAT_PERIOD);

  logic [N_BTN-1:0] rep_req;
  logic [N_BTN-1:0] pend_rep;

  for (genvar g = 0; g < N_BTN; g++) begin : g_repeat
    logic [RCW-1:0] hold_cnt;
    logic           repeating;

    // First threshold is the delay, later ones the period; a fresh pulse restarts the sequence.
    assign rep_req[g] = !btn_pulse[g] && btn_level[g] &&
                        ((hold_cnt + 1'b1) == (repeating ? PER : DLY));

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_cnt    <= '0;
        repeating   <= 1'b0;
        pend_rep[g] <= 1'b0;
      end else begin
        if (btn_pulse[g] || !btn_level[g]) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (rep_req[g]) begin
          hold_cnt  <= '0;
          repeating <= 1'b1;
        end else begin
          hold_cnt  <= hold_cnt + 1'b1;
        end
        if (btn_pulse[g])
          pend_rep[g] <= 1'b0;
        else if (rep_req[g] && !(pending[g] && !grant_vec[g]))
          pend_rep[g] <= 1'b1;
      end
    end
  end

  assign req        = btn_pulse | rep_req;
  assign entry      = {pend_rep[win_id], win_id};
  assign evt_repeat = mem[rd_ptr][EW-1];
`else
  localparam int unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_level;
  assign unused_level = ^btn_level;
  assign req          = btn_pulse;
  assign entry        = win_id;
  assign evt_repeat   = 1'b0;
`endif

  assign evt_valid = (fifo_count != '0);
  assign evt_id    = mem[rd_ptr][IDW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      pending <= (pending & ~grant_vec) | req;
      if (|(req & pending & ~grant_vec))
        overflow <= 1'b1;
      if (grant)
        rr_ptr <= next_rr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem        <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (grant) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (grant && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (!grant && pop)
        fifo_count <= fifo_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_button_event_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_pulse = '0;
  logic [3:0] btn_level = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [3:0] pending;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  button_event_arbiter #(.N_BTN(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_repeat(evt_repeat), .pending(pending), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event queue, per-button pending flags, next-search start.
  int q[$];
  bit m_pend[N];
  int m_rr;
  bit m_ovf;

  always @(posedge clk) begin
    int win;
    if (reset) begin
      q.delete();
      m_pend = '{default: 1'b0};
      m_rr   = 0;
      m_ovf  = 1'b0;
    end else begin
      win = -1;
      if (q.size() < D)
        for (int k = 0; k < N; k++)
          if (win < 0 && m_pend[(m_rr + k) % N]) win = (m_rr + k) % N;
      if (q.size() > 0 && evt_ready) void'(q.pop_front());
      if (win >= 0) begin
        q.push_back(win);
        m_pend[win] = 1'b0;
        m_rr = (win + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (btn_pulse[i]) begin
          if (m_pend[i]) m_ovf = 1'b1;
          m_pend[i] = 1'b1;
        end
    end
  end

  always @(negedge clk) begin
    logic [3:0] mp;
    if (model_on) begin
      for (int i = 0; i < N; i++) mp[i] = m_pend[i];
      check("m_valid", evt_valid, q.size() > 0);
      if (q.size() > 0) check("m_id", evt_id, q[0]);
      check("m_repeat", evt_repeat, 0);
      check("m_pending", pending, mp);
      check("m_count", fifo_count, q.size());
      check("m_overflow", overflow, m_ovf);
    end
  end

  task automatic drive(input logic [3:0] p, input logic r);
    btn_pulse = p;
    evt_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b0000, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    reset = 1'b0;
    model_on = 1'b1;
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_pending", pending, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);

    // single press on button 2
    drive(4'b0100, 1'b1);
    check("sp_pending", pending, 4'b0100);
    check("sp_valid_early", evt_valid, 0);
    drive(4'b0000, 1'b1);
    check("sp_valid", evt_valid, 1);
    check("sp_id", evt_id, 2);
    drive(4'b0000, 1'b1);
    check("sp_valid_after", evt_valid, 0);
    check("sp_count_after", fifo_count, 0);

    // simultaneous presses from a fresh reset
    do_reset();
    drive(4'b1111, 1'b0);
    for (int j = 0; j < 4; j++) begin
      drive(4'b0000, 1'b0);
      check("sim_count", fifo_count, j + 1);
    end
    check("sim_overflow", overflow, 0);
    check("sim_pending", pending, 0);
    for (int j = 0; j < 4; j++) begin
      check("sim_pop_id", evt_id, j);
      drive(4'b0000, 1'b1);
    end
    check("sim_empty", evt_valid, 0);

    // round-robin: grant button 1 so the search starts at 2
    drive(4'b0010, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0011, 1'b1);
    drive(4'b0000, 1'b1);
    check("rr_first", evt_id, 0);
    drive(4'b0000, 1'b1);
    check("rr_second", evt_id, 1);
    drive(4'b0000, 1'b1);
    drive(4'b1001, 1'b1);
    drive(4'b0000, 1'b1);
    check("rr_third", evt_id, 3);
    drive(4'b0000, 1'b1);
    check("rr_fourth", evt_id, 0);
    drive(4'b0000, 1'b1);
    check("rr_empty", evt_valid, 0);

    // full FIFO and coalescing overflow
    do_reset();
    for (int j = 0; j < 6; j++) begin
      drive(4'b0010, 1'b0);
      drive(4'b0000, 1'b0);
    end
    check("full_count", fifo_count, 4);
    check("full_pending", pending, 4'b0010);
    check("full_overflow", overflow, 1);
    drive(4'b0000, 1'b1);
    check("full_pop_count", fifo_count, 3);
    check("full_pop_pending", pending, 4'b0010);
    drive(4'b0000, 1'b0);
    check("full_refill_count", fifo_count, 4);
    check("full_refill_pending", pending, 0);

    // backpressure stability with 3 queued, then reset mid-operation
    drive(4'b0000, 1'b1);
    for (int j = 0; j < 20; j++) begin
      drive(4'b0000, 1'b0);
      check("bp_valid", evt_valid, 1);
      check("bp_id", evt_id, 1);
      check("bp_count", fifo_count, 3);
    end
    reset = 1'b1;
    drive(4'b0101, 1'b1);
    reset = 1'b0;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_overflow", overflow, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      btn_level = 4'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      drive(4'($urandom) & 4'($urandom), $urandom_range(0, 99) < 55);
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
